// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared constants, branch FSM encoding and helpers for the
//               pipeline hazard / control-flow sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int c_nregs     = 32;
    localparam int c_reg_idx_w = 5;
    localparam int c_dbits     = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BR_WAIT  = 2'd1,
        ST_REDIRECT = 2'd2
    } br_state_e;

    // from_AGEX_to_DE carries {stall, flush}; from_AGEX_to_FE carries {stall, redirect, target}
    localparam int c_agex_to_de_w = 2;
    localparam int c_agex_to_fe_w = 2 + c_dbits;

    function automatic logic is_tracked(input logic [c_reg_idx_w-1:0] r);
        return r != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : DE / AGEX / WB request signals and the stall, flush and
//               redirect fields returned by the hazard sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DBITS = c_dbits
) ();

    logic                   de_valid;
    logic [c_reg_idx_w-1:0] de_rs1;
    logic [c_reg_idx_w-1:0] de_rs2;
    logic                   de_rs1_used;
    logic                   de_rs2_used;
    logic [c_reg_idx_w-1:0] de_rd;
    logic                   de_wr_reg;
    logic                   de_is_branch;
    logic                   agex_br_valid;
    logic                   agex_br_taken;
    logic [DBITS-1:0]       agex_br_target;
    logic                   wb_valid;
    logic [c_reg_idx_w-1:0] wb_rd;

    logic                   stall_de;
    logic                   flush_de;
    logic                   fe_stall;
    logic                   fe_redirect;
    logic [DBITS-1:0]       fe_target;
    logic                   issue;
    logic                   sb_err;

    modport master (
        output de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd,
               de_wr_reg, de_is_branch, agex_br_valid, agex_br_taken,
               agex_br_target, wb_valid, wb_rd,
        input  stall_de, flush_de, fe_stall, fe_redirect, fe_target, issue, sb_err
    );

    modport slave (
        input  de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd,
               de_wr_reg, de_is_branch, agex_br_valid, agex_br_taken,
               agex_br_target, wb_valid, wb_rd,
        output stall_de, flush_de, fe_stall, fe_redirect, fe_target, issue, sb_err
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register in-flight write counters with saturating
//               inc/dec, error pulse and two combinational busy read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NREGS = c_nregs,
    parameter int CNTW  = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_inc_en,
    input  wire logic [c_reg_idx_w-1:0] i_inc_idx,
    input  wire logic                   i_dec_en,
    input  wire logic [c_reg_idx_w-1:0] i_dec_idx,
    input  wire logic [c_reg_idx_w-1:0] i_rd_idx_a,
    input  wire logic [c_reg_idx_w-1:0] i_rd_idx_b,
    output logic                        o_busy_a,
    output logic                        o_busy_b,
    output logic                        o_err
);

    localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};

    logic [NREGS-1:0][CNTW-1:0] w_cnt;
    logic [NREGS-1:0]           w_ovf;
    logic [NREGS-1:0]           w_unf;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
        if (gi == 0) begin : g_zero
            // x0 is hardwired zero and never tracked
            assign w_cnt[gi] = '0;
            assign w_ovf[gi] = 1'b0;
            assign w_unf[gi] = 1'b0;
        end else begin : g_track
            logic [CNTW-1:0] r_cnt;
            logic            w_inc;
            logic            w_dec;

            assign w_inc     = i_inc_en && (i_inc_idx == c_reg_idx_w'(gi));
            assign w_dec     = i_dec_en && (i_dec_idx == c_reg_idx_w'(gi));
            assign w_ovf[gi] = w_inc && !w_dec && (r_cnt == c_cnt_max);
            assign w_unf[gi] = w_dec && !w_inc && (r_cnt == '0);
            assign w_cnt[gi] = r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_inc && !w_dec && !w_ovf[gi]) begin
                    r_cnt <= r_cnt + CNTW'(1);
                end else if (w_dec && !w_inc && !w_unf[gi]) begin
                    r_cnt <= r_cnt - CNTW'(1);
                end
            end
        end
    end

    assign o_busy_a = is_tracked(i_rd_idx_a) && (w_cnt[i_rd_idx_a] != '0);
    assign o_busy_b = is_tracked(i_rd_idx_b) && (w_cnt[i_rd_idx_b] != '0);
    assign o_err    = |{w_ovf, w_unf};

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : RAW stall generation plus branch freeze / redirect / flush
//               sequencing between DE, AGEX and FE.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NREGS = c_nregs,
    parameter int DBITS = c_dbits,
    parameter int CNTW  = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipe_hazard_ctrl_if.slave hz
);

    br_state_e        r_state;
    logic             r_fe_stall;
    logic             r_redirect;
    logic [DBITS-1:0] r_fe_target;
    logic             r_sb_err;

    logic w_busy_rs1;
    logic w_busy_rs2;
    logic w_raw;
    logic w_stall_de;
    logic w_issue;
    logic w_sb_evt;
    logic w_inc_en;
    logic w_dec_en;
    logic w_agex_err;

    assign w_inc_en = w_issue && hz.de_wr_reg && is_tracked(hz.de_rd);
    assign w_dec_en = hz.wb_valid && is_tracked(hz.wb_rd);

    reg_scoreboard #(
        .NREGS (NREGS),
        .CNTW  (CNTW)
    ) u_sb (
        .clk        (clk),
        .rst        (reset),
        .i_inc_en   (w_inc_en),
        .i_inc_idx  (hz.de_rd),
        .i_dec_en   (w_dec_en),
        .i_dec_idx  (hz.wb_rd),
        .i_rd_idx_a (hz.de_rs1),
        .i_rd_idx_b (hz.de_rs2),
        .o_busy_a   (w_busy_rs1),
        .o_busy_b   (w_busy_rs2),
        .o_err      (w_sb_evt)
    );

    assign w_raw      = (hz.de_rs1_used && w_busy_rs1) || (hz.de_rs2_used && w_busy_rs2);
    assign w_stall_de = hz.de_valid && (w_raw || (r_state != ST_IDLE));
    assign w_issue    = hz.de_valid && !w_stall_de && !r_redirect;
    // A resolution only makes sense while a branch is outstanding
    assign w_agex_err = hz.agex_br_valid && (r_state != ST_BR_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fe_stall  <= 1'b0;
            r_redirect  <= 1'b0;
            r_fe_target <= '0;
            r_sb_err    <= 1'b0;
        end else begin
            r_sb_err <= r_sb_err || w_sb_evt || w_agex_err;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue && hz.de_is_branch) begin
                        r_state    <= ST_BR_WAIT;
                        r_fe_stall <= 1'b1;
                    end
                end
                ST_BR_WAIT: begin
                    if (hz.agex_br_valid) begin
                        r_fe_stall <= 1'b0;
                        if (hz.agex_br_taken) begin
                            r_state     <= ST_REDIRECT;
                            r_redirect  <= 1'b1;
                            r_fe_target <= hz.agex_br_target;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_REDIRECT: begin
                    r_state    <= ST_IDLE;
                    r_redirect <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_fe_stall <= 1'b0;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    assign hz.stall_de    = w_stall_de;
    assign hz.issue       = w_issue;
    assign hz.fe_stall    = r_fe_stall;
    assign hz.fe_redirect = r_redirect;
    assign hz.flush_de    = r_redirect;
    assign hz.fe_target   = r_fe_target;
    assign hz.sb_err      = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.DBITS(32)) hz ();

    pipe_hazard_ctrl #(
        .NREGS (32),
        .DBITS (32),
        .CNTW  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_ctl(input string tag, input logic st, input logic is,
                              input logic fs, input logic rd);
        check($sformatf("%s.stall_de", tag),    32'(hz.stall_de),    32'(st));
        check($sformatf("%s.issue", tag),       32'(hz.issue),       32'(is));
        check($sformatf("%s.fe_stall", tag),    32'(hz.fe_stall),    32'(fs));
        check($sformatf("%s.fe_redirect", tag), 32'(hz.fe_redirect), 32'(rd));
        check($sformatf("%s.flush_de", tag),    32'(hz.flush_de),    32'(rd));
    endtask

    task automatic clear_inputs();
        hz.de_valid       = 1'b0;
        hz.de_rs1         = '0;
        hz.de_rs2         = '0;
        hz.de_rs1_used    = 1'b0;
        hz.de_rs2_used    = 1'b0;
        hz.de_rd          = '0;
        hz.de_wr_reg      = 1'b0;
        hz.de_is_branch   = 1'b0;
        hz.agex_br_valid  = 1'b0;
        hz.agex_br_taken  = 1'b0;
        hz.agex_br_target = '0;
        hz.wb_valid       = 1'b0;
        hz.wb_rd          = '0;
    endtask

    // Inputs are applied 1 ns after the edge and outputs sampled 1 ns later
    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic de_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd, input logic wr,
                            input logic br);
        hz.de_valid     = 1'b1;
        hz.de_rs1       = rs1;
        hz.de_rs1_used  = u1;
        hz.de_rs2       = rs2;
        hz.de_rs2_used  = u2;
        hz.de_rd        = rd;
        hz.de_wr_reg    = wr;
        hz.de_is_branch = br;
    endtask

    task automatic retire(input logic [4:0] rd);
        hz.wb_valid = 1'b1;
        hz.wb_rd    = rd;
    endtask

    task automatic agex(input logic taken, input logic [31:0] target);
        hz.agex_br_valid  = 1'b1;
        hz.agex_br_taken  = taken;
        hz.agex_br_target = target;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        settle();
        expect_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.fe_target", hz.fe_target, 32'h0);
        check("reset.sb_err", 32'(hz.sb_err), 32'd0);

        // RAW on x5
        next_cycle(); reset = 1'b0;
        de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); settle();
        expect_ctl("raw.add", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); de_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); settle();
        expect_ctl("raw.stall1", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle(); de_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); retire(5'd5); settle();
        expect_ctl("raw.wbcyc", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle(); de_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); settle();
        expect_ctl("raw.release", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); retire(5'd6); settle();
        check("raw.sb_err", 32'(hz.sb_err), 32'd0);

        // x0 destination / source
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); settle();
        expect_ctl("x0.write", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); de_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); retire(5'd0); settle();
        expect_ctl("x0.read", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); settle();
        check("x0.sb_err", 32'(hz.sb_err), 32'd0);

        // Taken branch
        next_cycle(); de_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1); settle();
        expect_ctl("tk.issue", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); de_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
        agex(1'b1, 32'h0000_0040); settle();
        expect_ctl("tk.wait", 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle(); de_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0); settle();
        expect_ctl("tk.redir", 1'b1, 1'b0, 1'b0, 1'b1);
        check("tk.fe_target", hz.fe_target, 32'h0000_0040);
        next_cycle(); de_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0); settle();
        expect_ctl("tk.idle", 1'b0, 1'b1, 1'b0, 1'b0);

        // Not-taken branch
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); settle();
        expect_ctl("nt.issue", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        agex(1'b0, 32'h0000_0080); settle();
        expect_ctl("nt.wait", 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        expect_ctl("nt.resume", 1'b0, 1'b1, 1'b0, 1'b0);
        check("nt.fe_target", hz.fe_target, 32'h0000_0040);
        check("nt.sb_err", 32'(hz.sb_err), 32'd0);

        // Simultaneous inc/dec on x7
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); settle();
        check("sim.w1.issue", 32'(hz.issue), 32'd1);
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); retire(5'd7); settle();
        check("sim.w2.issue", 32'(hz.issue), 32'd1);
        next_cycle(); de_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        check("sim.held", 32'(hz.stall_de), 32'd1);
        next_cycle(); retire(5'd7); settle();
        next_cycle(); de_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        check("sim.clear", 32'(hz.stall_de), 32'd0);
        check("sim.sb_err", 32'(hz.sb_err), 32'd0);

        // Overflow: four writes to x7 with no retire
        for (int i = 0; i < 4; i++) begin
            next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); settle();
            check($sformatf("ovf.w%0d.issue", i), 32'(hz.issue), 32'd1);
        end
        check("ovf.err_before", 32'(hz.sb_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); de_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); retire(5'd7); settle();
            check($sformatf("ovf.drain%0d.stall", i), 32'(hz.stall_de), 32'd1);
        end
        check("ovf.sb_err", 32'(hz.sb_err), 32'd1);
        next_cycle(); de_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); settle();
        check("ovf.drained", 32'(hz.stall_de), 32'd0);
        check("ovf.sticky", 32'(hz.sb_err), 32'd1);

        // Reset while in BR_WAIT with two writes to x3 in flight
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); settle();
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); settle();
        next_cycle(); de_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); settle();
        check("rst.br_issue", 32'(hz.issue), 32'd1);
        next_cycle(); reset = 1'b1; settle();
        check("rst.in_wait", 32'(hz.fe_stall), 32'd1);
        next_cycle(); reset = 1'b0;
        de_instr(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0); settle();
        expect_ctl("rst.after", 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst.fe_target", hz.fe_target, 32'h0);
        check("rst.sb_err", 32'(hz.sb_err), 32'd0);

        // Stray AGEX resolution while idle
        next_cycle(); agex(1'b1, 32'h0000_0100); settle();
        check("stray.before", 32'(hz.sb_err), 32'd0);
        next_cycle(); settle();
        check("stray.err", 32'(hz.sb_err), 32'd1);
        check("stray.no_redir", 32'(hz.fe_redirect), 32'd0);

        // Underflow: retire of an untracked-but-idle register
        next_cycle(); reset = 1'b1; settle();
        next_cycle(); reset = 1'b0; retire(5'd9); settle();
        check("unf.before", 32'(hz.sb_err), 32'd0);
        next_cycle(); settle();
        check("unf.err", 32'(hz.sb_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
